// File: rtl/hc4e_pkg.sv
// Shared types and widths for the HC4e RAM responder.
package hc4e_pkg;

    localparam int HC4E_DATA_W = 4;
    localparam int HC4E_ADDR_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } hc4e_state_e;

endpackage

// File: rtl/hc4e_strobe_sync.sv
// Multi-flop synchronizer for an active-low strobe; every stage resets to 1 (inactive).
module hc4e_strobe_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic sync_out
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], async_in};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign sync_out = sync_q[STAGES-1];

endmodule

// File: rtl/hc4e_ram.sv
// RAM responder for the HC4e core's 4-bit bus: synchronizes the core's strobes,
// services one access per strobe, and offers a host preload/dump port.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | waiting for exactly one synchronized strobe to go low
// ST_READ  | rdata_q latched; driving data_bus while raw nRAM_RD is low
// ST_WRITE | write committed on entry; waiting for nRAM_WR to return high
module hc4e_ram
    import hc4e_pkg::*;
#(
    parameter int ADDR_W      = HC4E_ADDR_W,
    parameter int DATA_W      = HC4E_DATA_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              nRAM_RD,
    input  logic              nRAM_WR,
    input  logic [3:0]        addr_lo,
    input  logic [3:0]        addr_hi,
    inout  wire  [DATA_W-1:0] data_bus,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic [DATA_W-1:0] host_rdata,
    output logic              busy,
    output logic              proto_err,
    output logic [7:0]        acc_count
);

    localparam int DEPTH = 1 << ADDR_W;

    logic              rd_s;
    logic              wr_s;
    hc4e_state_e       state_q, state_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [DATA_W-1:0] host_rdata_q, host_rdata_d;
    logic              proto_err_q, proto_err_d;
    logic [7:0]        acc_count_q, acc_count_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [ADDR_W-1:0] cpu_addr;
    logic              cpu_we;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    assign cpu_addr = {addr_hi, addr_lo};

    hc4e_strobe_sync #(.STAGES(SYNC_STAGES)) u_sync_rd (
        .clk      (clk),
        .reset    (reset),
        .async_in (nRAM_RD),
        .sync_out (rd_s)
    );

    hc4e_strobe_sync #(.STAGES(SYNC_STAGES)) u_sync_wr (
        .clk      (clk),
        .reset    (reset),
        .async_in (nRAM_WR),
        .sync_out (wr_s)
    );

    always_comb begin
        state_d     = state_q;
        rdata_d     = rdata_q;
        proto_err_d = proto_err_q;
        acc_count_d = acc_count_q;
        cpu_we      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!rd_s && wr_s) begin
                    state_d = ST_READ;
                    rdata_d = mem_q[cpu_addr];
                end else if (!wr_s && rd_s) begin
                    state_d = ST_WRITE;
                    cpu_we  = 1'b1;
                end else if (!rd_s && !wr_s) begin
                    proto_err_d = 1'b1;
                end
            end
            ST_READ: begin
                if (rd_s) begin
                    state_d     = ST_IDLE;
                    acc_count_d = acc_count_q + 8'd1;
                end
            end
            ST_WRITE: begin
                if (wr_s) begin
                    state_d     = ST_IDLE;
                    acc_count_d = acc_count_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A host write landing on the CPU commit cycle takes the single write port.
        if (cpu_we && host_we) begin
            proto_err_d = 1'b1;
        end

        host_rdata_d = mem_q[host_addr];
    end

    always_comb begin
        mem_we    = host_we || (cpu_we && !reset);
        mem_waddr = host_we ? host_addr  : cpu_addr;
        mem_wdata = host_we ? host_wdata : data_bus;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            rdata_q      <= '0;
            host_rdata_q <= '0;
            proto_err_q  <= 1'b0;
            acc_count_q  <= 8'd0;
        end else begin
            state_q      <= state_d;
            rdata_q      <= rdata_d;
            host_rdata_q <= host_rdata_d;
            proto_err_q  <= proto_err_d;
            acc_count_q  <= acc_count_d;
        end
    end

    // Storage is deliberately outside the reset domain so contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    // Raw pin and raw reset gate the driver so release never waits for a clock.
    assign data_bus = (state_q == ST_READ && !nRAM_RD && !reset) ? rdata_q : 'z;

    assign busy       = (state_q != ST_IDLE);
    assign proto_err  = proto_err_q;
    assign acc_count  = acc_count_q;
    assign host_rdata = host_rdata_q;

endmodule

// File: tb/tb_hc4e_ram.sv
// Scoreboard bench for hc4e_ram: host and CPU accesses checked against a memory model.
module tb_hc4e_ram;

    logic       clk = 1'b0;
    logic       reset;
    logic       nRAM_RD;
    logic       nRAM_WR;
    logic [3:0] addr_lo;
    logic [3:0] addr_hi;
    tri1  [3:0] data_bus;
    logic       host_we;
    logic [7:0] host_addr;
    logic [3:0] host_wdata;
    logic [3:0] host_rdata;
    logic       busy;
    logic       proto_err;
    logic [7:0] acc_count;

    logic       tb_drv_en;
    logic [3:0] tb_drv;

    logic [3:0] mdl [256];
    logic [7:0] exp_q [$];
    int         n_chk = 0;
    int         n_err = 0;

    assign data_bus = tb_drv_en ? tb_drv : 4'bz;

    always #5 clk = ~clk;

    hc4e_ram dut (
        .clk        (clk),
        .reset      (reset),
        .nRAM_RD    (nRAM_RD),
        .nRAM_WR    (nRAM_WR),
        .addr_lo    (addr_lo),
        .addr_hi    (addr_hi),
        .data_bus   (data_bus),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_rdata (host_rdata),
        .busy       (busy),
        .proto_err  (proto_err),
        .acc_count  (acc_count)
    );

    task automatic check_val(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic host_wr(input logic [7:0] a, input logic [3:0] d);
        host_we    = 1'b1;
        host_addr  = a;
        host_wdata = d;
        tick(1);
        host_we    = 1'b0;
        mdl[a]     = d;
    endtask

    task automatic host_rd(input logic [7:0] a);
        logic [7:0] e;
        host_addr = a;
        exp_q.push_back({4'h0, mdl[a]});
        tick(1);
        e = exp_q.pop_front();
        check_val("host_rdata", {4'h0, host_rdata}, e);
    endtask

    task automatic cpu_read(input logic [7:0] a);
        logic [7:0] e;
        {addr_hi, addr_lo} = a;
        nRAM_RD = 1'b0;
        exp_q.push_back({4'h0, mdl[a]});
        tick(2);
        check_val("rd_not_early", {7'h0, busy}, 8'h0);
        tick(1);
        check_val("rd_busy", {7'h0, busy}, 8'h1);
        e = exp_q.pop_front();
        check_val("rd_data", {4'h0, data_bus}, e);
        nRAM_RD = 1'b1;
        #1;
        check_val("rd_release", {4'h0, data_bus}, 8'h0F);
        tick(2);
        check_val("rd_busy_hold", {7'h0, busy}, 8'h1);
        tick(1);
        check_val("rd_busy_drop", {7'h0, busy}, 8'h0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        nRAM_RD = 1'b1;
        nRAM_WR = 1'b1;
        addr_lo = '0;
        addr_hi = '0;
        host_we = 1'b0;
        host_addr = '0;
        host_wdata = '0;
        tb_drv_en = 1'b0;
        tb_drv = '0;
        for (int i = 0; i < 256; i++) mdl[i] = 4'h0;

        tick(3);
        check_val("rst_busy", {7'h0, busy}, 8'h0);
        check_val("rst_err", {7'h0, proto_err}, 8'h0);
        check_val("rst_acc", acc_count, 8'h0);
        check_val("rst_hrdata", {4'h0, host_rdata}, 8'h0);
        check_val("rst_bus", {4'h0, data_bus}, 8'h0F);
        reset = 1'b0;
        tick(1);

        // host preload then CPU read at 0x3A
        host_wr(8'h3A, 4'h7);
        host_rd(8'h3A);
        cpu_read(8'h3A);
        check_val("acc_after_rd", acc_count, 8'd1);

        // CPU write 0x5 to 0xFF with a 6-cycle strobe; data changes after commit
        {addr_hi, addr_lo} = 8'hFF;
        tb_drv = 4'h5;
        tb_drv_en = 1'b1;
        nRAM_WR = 1'b0;
        tick(4);
        tb_drv = 4'hA;
        tick(2);
        nRAM_WR = 1'b1;
        tb_drv_en = 1'b0;
        mdl[8'hFF] = 4'h5;
        tick(3);
        check_val("wr_busy_drop", {7'h0, busy}, 8'h0);
        check_val("acc_after_wr", acc_count, 8'd2);
        host_rd(8'hFF);
        cpu_read(8'hFF);
        check_val("acc_after_rd2", acc_count, 8'd3);

        // both strobes low together
        nRAM_RD = 1'b0;
        nRAM_WR = 1'b0;
        tick(5);
        check_val("both_err", {7'h0, proto_err}, 8'h1);
        check_val("both_busy", {7'h0, busy}, 8'h0);
        check_val("both_bus", {4'h0, data_bus}, 8'h0F);
        nRAM_RD = 1'b1;
        nRAM_WR = 1'b1;
        tick(4);
        check_val("both_acc", acc_count, 8'd3);
        check_val("err_sticky", {7'h0, proto_err}, 8'h1);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(1);
        check_val("err_cleared", {7'h0, proto_err}, 8'h0);
        check_val("acc_cleared", acc_count, 8'h0);

        // reset in the middle of a read
        host_wr(8'h20, 4'hC);
        {addr_hi, addr_lo} = 8'h20;
        nRAM_RD = 1'b0;
        tick(3);
        check_val("mid_rd_data", {4'h0, data_bus}, 8'h0C);
        reset = 1'b1;
        #1;
        check_val("mid_rst_bus", {4'h0, data_bus}, 8'h0F);
        tick(1);
        check_val("mid_rst_busy", {7'h0, busy}, 8'h0);
        nRAM_RD = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(4);
        check_val("mid_rst_busy2", {7'h0, busy}, 8'h0);
        check_val("mid_rst_acc", acc_count, 8'h0);
        host_rd(8'h20);
        host_rd(8'h3A);

        // CPU write commit collides with host write at 0x10
        check_val("coll_err_pre", {7'h0, proto_err}, 8'h0);
        {addr_hi, addr_lo} = 8'h10;
        tb_drv = 4'h9;
        tb_drv_en = 1'b1;
        nRAM_WR = 1'b0;
        tick(2);
        host_we = 1'b1;
        host_addr = 8'h10;
        host_wdata = 4'h2;
        tick(1);
        host_we = 1'b0;
        mdl[8'h10] = 4'h2;
        check_val("coll_busy", {7'h0, busy}, 8'h1);
        check_val("coll_err", {7'h0, proto_err}, 8'h1);
        tick(1);
        nRAM_WR = 1'b1;
        tb_drv_en = 1'b0;
        tick(4);
        host_rd(8'h10);

        // 256 accesses wrap the counter
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(1);
        for (int i = 0; i < 256; i++) begin
            cpu_read(8'h3A);
            if (i == 254) check_val("acc_255", acc_count, 8'd255);
        end
        check_val("acc_wrap", acc_count, 8'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/hc4e_ram.md
# hc4e_ram

Target-side RAM responder for the HC4e core's 4-bit data bus: services the core's active-low `nRAM_RD` / `nRAM_WR` strobes, using the address the core presents on its stack outputs (`{stackB_out, stackA_out}`). Runs on its own faster system clock and treats the core's strobes as asynchronous. Contains a 256×4 storage array and a host preload/dump port for bench and boot loading.

## Interface
- `ADDR_W`, 8, address width; address is `{addr_hi, addr_lo}`.
- `DATA_W`, 4, data width; must match the core's data bus.
- `SYNC_STAGES`, 2, synchronizer depth on the strobes (≥2).
- `clk`  in  1  responder clock; must be ≥8× the core clock.
- `reset`  in  1  synchronous, active-high reset.
- `nRAM_RD`  in  1  core read strobe, active low, asynchronous to `clk`.
- `nRAM_WR`  in  1  core write strobe, active low, asynchronous to `clk`.
- `addr_lo`  in  4  from core `stackA_out`.
- `addr_hi`  in  4  from core `stackB_out`.
- `data_bus`  inout  DATA_W  shared with the core; driven only during reads.
- `host_we`  in  1  host write enable.
- `host_addr`  in  ADDR_W  host address.
- `host_wdata`  in  DATA_W  host write data.
- `host_rdata`  out  DATA_W  host read data, registered; reset value 0.
- `busy`  out  1  FSM not IDLE; reset value 0.
- `proto_err`  out  1  sticky protocol error; reset value 0.
- `acc_count`  out  8  completed CPU accesses, wraps at 255→0; reset value 0.

## Operation
- Strobes pass through SYNC_STAGES flops, reset to 1 (inactive), giving `rd_s` and `wr_s`.
- FSM states: IDLE, READ, WRITE.
- IDLE → READ when `rd_s==0 && wr_s==1`. On this edge, latch `rdata_q <= mem[{addr_hi,addr_lo}]`.
- IDLE → WRITE when `wr_s==0 && rd_s==1`. On this edge, perform one write: `mem[addr] <= data_bus`.
- IDLE with both `rd_s` and `wr_s` at 0: stay in IDLE, set `proto_err`, perform no access.
- READ → IDLE and WRITE → IDLE when the respective synchronized strobe returns to 1. `acc_count` increments on that exit edge.
- A strobe held low produces exactly one access. Re-entry requires passing through IDLE.
- Bus drive: `data_bus = rdata_q` iff `state==READ && nRAM_RD==0`, using the raw pin. This releases the bus combinationally the moment the core ends the strobe, so there is no contention with a following ALU cycle. Otherwise `data_bus` is high-Z.
- Host port: `host_rdata <= mem[host_addr]` every cycle. A host write performs `mem[host_addr] <= host_wdata`.
- Host write in the same cycle as a CPU write commit: the host write wins, the CPU write is dropped, and `proto_err` is set.
- `reset` clears the FSM, synchronizers, `rdata_q`, the outputs and `acc_count`. Memory contents are not cleared.
- Reset mid-access: the FSM returns to IDLE, the bus is released immediately, and the in-flight access is not counted.

## Timing
- Read latency: the bus is driven after the (SYNC_STAGES+1)th `clk` rising edge following the `nRAM_RD` falling edge. With defaults this is 3 edges.
- Clock ratio: ≥8× means the core's low clock phase spans ≥4 `clk` edges, so data is valid before the core's sampling posedge.
- Write commit: (SYNC_STAGES+1) edges after `nRAM_WR` falls. `data_bus` has been stable ≥2 cycles by then.
- Bus release: combinational on the `nRAM_RD` rising edge.
- `busy` deasserts SYNC_STAGES+1 edges after the strobe rises.
- Host read latency: 1 cycle. Host write is visible to the CPU on the next access.

## Structure
- Shared package `hc4e_pkg` holds:
  - the FSM state enum (IDLE/READ/WRITE);
  - `HC4E_DATA_W=4` and `HC4E_ADDR_W=8`.
- Sub-module `hc4e_strobe_sync` is a parameterized-depth synchronizer with reset-to-1. It is instantiated twice.
- Storage is an inferred array with two write paths muxed by the priority rule above.

## Test plan
- Host writes mem[0x3A]=0x7; core issues a read at addr_hi=3, addr_lo=A → `data_bus`=0x7 by the 3rd `clk` edge; high-Z within 0 cycles of `nRAM_RD` rising; `acc_count`=1.
- Core write, `data_bus`=0x5 at addr 0xFF → host read of 0xFF returns 0x5 after 1 cycle; exactly one write despite a 6-cycle-long strobe.
- Both strobes low simultaneously → no access, `proto_err`=1, bus high-Z; `proto_err` persists until `reset`.
- CPU write commit to 0x10 (data 0x9) coincides with host write to 0x10 (data 0x2) → mem[0x10]=0x2, `proto_err`=1.
- Assert `reset` during READ → bus high-Z immediately, `busy`=0, `acc_count` unchanged; mem contents retained.
- 256 back-to-back accesses → `acc_count` wraps 255→0.
